// File: rtl/lzss_decoder.sv
// lzss_decoder: expands an LZSS token stream (literals and distance/length
// back-references) into the original word stream using a circular history.
module lzss_decoder #(
   parameter int WORD_SIZE       = 4,
   parameter int WINDOW_SIZE     = 16,
   parameter int LOOK_AHEAD_SIZE = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WORD_SIZE:0]   data_i,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WORD_SIZE-1:0] data_o,
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic                 err
);
   localparam int AW = $clog2(WINDOW_SIZE);
   localparam int LW = LOOK_AHEAD_SIZE > 1 ? $clog2(LOOK_AHEAD_SIZE) : 1;
   localparam logic [AW:0] FULL = (AW+1)'(WINDOW_SIZE);

   typedef enum logic [1:0] {S_TOKEN, S_LEN, S_COPY} state_t;

   state_t               r_state, w_next;
   logic [WORD_SIZE-1:0] r_hist [WINDOW_SIZE];
   logic [AW-1:0]        r_wptr;
   logic [AW:0]          r_fill, r_dist;
   logic [LW-1:0]        r_cnt;
   logic [WORD_SIZE-1:0] r_data, w_word;
   logic                 r_valid, r_err;
   logic                 w_adv, w_acc, w_rdy, w_emit, w_ld_dist, w_ld_len, w_set_err;
   logic [AW-1:0]        w_rd;

   assign w_adv    = !r_valid || o_ready;
   assign in_ready = w_rdy && !rst;
   assign w_acc    = in_valid && in_ready;
   assign w_rd     = r_wptr - r_dist[AW-1:0];
   assign data_o   = r_data;
   assign o_valid  = r_valid;
   assign err      = r_err;

   always_comb begin
      w_next    = r_state;
      w_rdy     = 1'b0;
      w_emit    = 1'b0;
      w_word    = data_i[WORD_SIZE-1:0];
      w_ld_dist = 1'b0;
      w_ld_len  = 1'b0;
      w_set_err = 1'b0;
      case (r_state)
         S_TOKEN: begin
            w_rdy = w_adv;
            if (w_acc) begin
               w_ld_dist = data_i[WORD_SIZE];
               w_emit    = !data_i[WORD_SIZE];
               w_next    = data_i[WORD_SIZE] ? S_LEN : S_TOKEN;
            end
         end
         S_LEN: begin
            // a stray literal here is emitted, so it must also wait for the output register
            w_rdy = data_i[WORD_SIZE] || w_adv;
            if (w_acc) begin
               w_set_err = !data_i[WORD_SIZE] || (r_dist > r_fill);
               w_emit    = !data_i[WORD_SIZE];
               w_ld_len  = data_i[WORD_SIZE] && (r_dist <= r_fill);
               w_next    = w_ld_len ? S_COPY : S_TOKEN;
            end
         end
         default: begin
            if (w_adv) begin
               w_emit = 1'b1;
               w_word = r_hist[w_rd];
               w_next = (r_cnt == '0) ? S_TOKEN : S_COPY;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_TOKEN;
         r_wptr  <= '0;
         r_fill  <= '0;
         r_dist  <= '0;
         r_cnt   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_set_err) r_err <= 1'b1;
         if (w_ld_dist) r_dist <= {1'b0, data_i[AW-1:0]} + 1'b1;
         if (w_ld_len) r_cnt <= data_i[LW-1:0];
         else if (r_state == S_COPY && w_adv) r_cnt <= r_cnt - 1'b1;
         if (w_emit) begin
            r_data  <= w_word;
            r_valid <= 1'b1;
            r_wptr  <= r_wptr + 1'b1;
            r_fill  <= (r_fill == FULL) ? r_fill : r_fill + 1'b1;
         end else if (o_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   // history is not reset; fill alone decides which entries are meaningful
   always_ff @(posedge clk) begin
      if (w_emit) r_hist[r_wptr] <= w_word;
   end
endmodule

// File: tb/tb_lzss_decoder.sv
// tb_lzss_decoder: scoreboard bench for lzss_decoder; expected words are queued
// as tokens are sent and compared as the decoder hands them downstream.
module tb_lzss_decoder;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] data_i = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] data_o;
   logic       o_valid;
   logic       o_ready = 1'b1;
   logic       err;

   int         vectors = 0;
   int         miscompares = 0;
   logic [3:0] exp_q [$];

   lzss_decoder #(.WORD_SIZE(4), .WINDOW_SIZE(16), .LOOK_AHEAD_SIZE(4)) dut (
      .clk(clk), .rst(rst), .data_i(data_i), .in_valid(in_valid), .in_ready(in_ready),
      .data_o(data_o), .o_valid(o_valid), .o_ready(o_ready), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && o_valid && o_ready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output: got %h, none expected", data_o);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if (data_o !== e) begin
               miscompares++;
               $display("FAIL scoreboard: got %h, expected %h", data_o, e);
            end
         end
      end
   end

   task automatic send(input logic [4:0] t);
      int n;
      n = 0;
      data_i   = t;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout: token %h, in_ready still 0", t);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic lit(input logic [3:0] w);
      exp_q.push_back(w);
      send({1'b0, w});
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d words outstanding, expected 0", exp_q.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      o_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({in_ready, o_valid, err, data_o} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_state: in_ready=%b o_valid=%b err=%b data_o=%h, expected all 0",
                  in_ready, o_valid, err, data_o);
      end
      exp_q.delete();
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_literals();
      for (int i = 0; i < 16; i++) begin
         lit(4'(i));
         vectors++;
         if (o_valid !== 1'b1 || data_o !== 4'(i) || err !== 1'b0) begin
            miscompares++;
            $display("FAIL literal_latency: o_valid=%b data_o=%h err=%b, expected 1 %h 0",
                     o_valid, data_o, err, 4'(i));
         end
      end
      drain();
   endtask

   task automatic test_copy();
      int n;
      lit(4'h1); lit(4'h2); lit(4'h3);
      exp_q.push_back(4'h1); exp_q.push_back(4'h2); exp_q.push_back(4'h3);
      send(5'h12);
      send(5'h12);
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         if (in_ready) break;
         n++;
      end
      vectors++;
      if (n != 3) begin
         miscompares++;
         $display("FAIL copy_busy: in_ready low for %0d cycles, expected 3", n);
      end
      drain();
   endtask

   task automatic test_overlap();
      lit(4'hA);
      repeat (4) exp_q.push_back(4'hA);
      send(5'h10);
      send(5'h13);
      drain();
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 20; i++) lit(4'(i));
      exp_q.push_back(4'h4); exp_q.push_back(4'h5);
      send(5'h1F);
      send(5'h11);
      drain();
   endtask

   task automatic test_bad_distance();
      test_reset();
      lit(4'h7); lit(4'h8);
      send(5'h14);
      send(5'h10);
      vectors++;
      if (err !== 1'b1) begin
         miscompares++;
         $display("FAIL bad_distance_err: err=%b, expected 1", err);
      end
      lit(4'h9);
      drain();
      vectors++;
      if (err !== 1'b1) begin
         miscompares++;
         $display("FAIL err_sticky: err=%b, expected 1", err);
      end
   endtask

   task automatic test_stall_and_reset();
      logic [3:0] held;
      test_reset();
      for (int i = 1; i <= 4; i++) lit(4'(i));
      for (int i = 1; i <= 4; i++) exp_q.push_back(4'(i));
      send(5'h13);
      send(5'h13);
      o_ready = 1'b0;
      @(posedge clk);
      #1 held = data_o;
      vectors++;
      if (o_valid !== 1'b1 || held !== 4'h1) begin
         miscompares++;
         $display("FAIL stall_first: o_valid=%b data_o=%h, expected 1 1", o_valid, held);
      end
      repeat (3) begin
         @(negedge clk);
         vectors++;
         if (o_valid !== 1'b1 || data_o !== held) begin
            miscompares++;
            $display("FAIL stall_hold: o_valid=%b data_o=%h, expected 1 %h", o_valid, data_o, held);
         end
      end
      o_ready = 1'b1;
      drain();
      lit(4'h5);
      drain();
      send(5'h10);
      send(5'h13);
      o_ready = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      vectors++;
      if (o_valid !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: o_valid=%b err=%b in_ready=%b, expected 0 0 0",
                  o_valid, err, in_ready);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      o_ready = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (in_ready !== 1'b1 || o_valid !== 1'b0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL after_reset: in_ready=%b o_valid=%b err=%b, expected 1 0 0",
                  in_ready, o_valid, err);
      end
      lit(4'hC);
      drain();
   endtask

   initial begin
      test_reset();
      test_literals();
      test_copy();
      test_overlap();
      test_wrap();
      test_bad_distance();
      test_stall_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
